// File: rtl/rst_seq.sv
// Reset sequencer: waits for a filtered PLL lock, then releases N_CH domain resets in index order.
// Optional lock-loss statistics counter is built only when RST_SEQ_STATS_EN is defined.
module rst_seq #(
    parameter int N_CH        = 4,
    parameter int STRETCH_LEN = 16,
    parameter int LOCK_FILT   = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            pll_lock,
    input  logic [N_CH-1:0] sw_rst_req,
    output logic [N_CH-1:0] rst_out,
    output logic            ready,
    output logic [7:0]      lock_loss_cnt
);

    localparam int CNT_W = $clog2(STRETCH_LEN + 1);
    localparam int CH_W  = $clog2(N_CH + 1);
    localparam int FLT_W = $clog2(LOCK_FILT + 1);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STRETCH_LEN - 1);
    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(N_CH - 1);
    localparam logic [FLT_W-1:0] FLT_MAX  = FLT_W'(LOCK_FILT);

    typedef enum logic [1:0] {
        WAIT_LOCK,
        STRETCH,
        RUN
    } state_t;

    state_t           state, state_nxt;
    logic [CH_W-1:0]  ch, ch_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [N_CH-1:0]  rst_nxt;
    logic             ready_nxt;

    logic             sync1, lock_s;
    logic [FLT_W-1:0] filt;
    logic             lock_ok;

    logic             req_any;
    logic [CH_W-1:0]  req_idx;
    logic [N_CH-1:0]  hold_mask;
    logic [N_CH-1:0]  rel_mask;

    // Two-flop synchroniser followed by a saturating run-length filter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1  <= 1'b0;
            lock_s <= 1'b0;
            filt   <= '0;
        end else begin
            sync1  <= pll_lock;
            lock_s <= sync1;
            if (!lock_s)
                filt <= '0;
            else if (filt != FLT_MAX)
                filt <= filt + FLT_W'(1);
        end
    end

    assign lock_ok = (filt == FLT_MAX);

    // Lowest requesting index wins; hold_mask covers that domain and everything after it
    always_comb begin
        req_any   = |sw_rst_req;
        req_idx   = '0;
        hold_mask = '0;
        rel_mask  = '0;
        for (int j = N_CH - 1; j >= 0; j--) begin
            if (sw_rst_req[j])
                req_idx = CH_W'(j);
        end
        for (int j = 0; j < N_CH; j++) begin
            hold_mask[j] = (CH_W'(j) >= req_idx);
            rel_mask[j]  = (CH_W'(j) == ch);
        end
    end

    always_comb begin
        state_nxt = state;
        ch_nxt    = ch;
        cnt_nxt   = cnt;
        rst_nxt   = rst_out;
        ready_nxt = ready;
        unique case (state)
            WAIT_LOCK: begin
                if (lock_ok) begin
                    state_nxt = STRETCH;
                    ch_nxt    = '0;
                    cnt_nxt   = '0;
                end
            end
            STRETCH, RUN: begin
                if (!lock_ok) begin
                    // Lock loss outranks any software request this cycle
                    state_nxt = WAIT_LOCK;
                    ch_nxt    = '0;
                    cnt_nxt   = '0;
                    rst_nxt   = '1;
                    ready_nxt = 1'b0;
                end else if (req_any && (state == RUN || req_idx <= ch)) begin
                    state_nxt = STRETCH;
                    ch_nxt    = req_idx;
                    cnt_nxt   = '0;
                    rst_nxt   = rst_out | hold_mask;
                    ready_nxt = 1'b0;
                end else if (state == STRETCH) begin
                    if (cnt == CNT_LAST) begin
                        rst_nxt = rst_out & ~rel_mask;
                        cnt_nxt = '0;
                        if (ch == CH_LAST) begin
                            state_nxt = RUN;
                            ready_nxt = 1'b1;
                        end else begin
                            ch_nxt = ch + CH_W'(1);
                        end
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_nxt = WAIT_LOCK;
                ch_nxt    = '0;
                cnt_nxt   = '0;
                rst_nxt   = '1;
                ready_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= WAIT_LOCK;
            ch      <= '0;
            cnt     <= '0;
            rst_out <= '1;
            ready   <= 1'b0;
        end else begin
            state   <= state_nxt;
            ch      <= ch_nxt;
            cnt     <= cnt_nxt;
            rst_out <= rst_nxt;
            ready   <= ready_nxt;
        end
    end

`ifdef RST_SEQ_STATS_EN
    logic lost;
    assign lost = (state != WAIT_LOCK) && !lock_ok;

    always_ff @(posedge clk) begin
        if (!rst_n)
            lock_loss_cnt <= 8'h00;
        else if (lost && lock_loss_cnt != 8'hFF)
            lock_loss_cnt <= lock_loss_cnt + 8'd1;
    end
`else
    assign lock_loss_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_rst_seq.sv
// Randomised and directed bench for rst_seq against a release-count reference model.
// The model tracks how many domains are released rather than any FSM encoding.
module tb_rst_seq;

    localparam int N_CH = 4;
    localparam int SL   = 16;
    localparam int LF   = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            pll_lock = 1'b0;
    logic [N_CH-1:0] sw_rst_req = '0;
    logic [N_CH-1:0] rst_out;
    logic            ready;
    logic [7:0]      lock_loss_cnt;

    rst_seq #(.N_CH(N_CH), .STRETCH_LEN(SL), .LOCK_FILT(LF)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pll_lock     (pll_lock),
        .sw_rst_req   (sw_rst_req),
        .rst_out      (rst_out),
        .ready        (ready),
        .lock_loss_cnt(lock_loss_cnt)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: pll_lock sample history, sequencing flag, released count, stretch timer
    bit hist [LF+2];
    bit up;
    int n_rel;
    int tmr;
    int m_losses;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [N_CH-1:0] exp_rst();
        logic [N_CH-1:0] m;
        m = '0;
        for (int j = 0; j < N_CH; j++)
            m[j] = (j >= n_rel);
        return m;
    endfunction

    function automatic logic [7:0] exp_llc();
`ifdef RST_SEQ_STATS_EN
        return 8'(m_losses);
`else
        return 8'h00;
`endif
    endfunction

    task automatic model_step();
        bit ok;
        int li;
        if (!rst_n) begin
            for (int k = 0; k < LF + 2; k++) hist[k] = 1'b0;
            up = 1'b0; n_rel = 0; tmr = 0; m_losses = 0;
        end else begin
            // Lock is good when the LOCK_FILT samples taken 3..LF+2 edges ago were all high
            ok = 1'b1;
            for (int k = 2; k < LF + 2; k++)
                if (!hist[k]) ok = 1'b0;
            if (!up) begin
                if (ok) begin up = 1'b1; n_rel = 0; tmr = 0; end
            end else if (!ok) begin
                up = 1'b0; n_rel = 0; tmr = 0;
                if (m_losses < 255) m_losses++;
            end else begin
                li = -1;
                for (int i = 0; i < N_CH; i++)
                    if (sw_rst_req[i] && li < 0) li = i;
                if (li >= 0 && li <= n_rel) begin
                    n_rel = li; tmr = 0;
                end else if (n_rel < N_CH) begin
                    tmr++;
                    if (tmr == SL) begin n_rel++; tmr = 0; end
                end
            end
            for (int k = LF + 1; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = pll_lock;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("rst_out", 32'(rst_out), 32'(exp_rst()));
        chk("ready", 32'(ready), 32'(up && n_rel == N_CH));
        chk("lock_loss_cnt", 32'(lock_loss_cnt), 32'(exp_llc()));
    endtask

    int fall [N_CH];
    int rdy_rise;
    logic [N_CH-1:0] prev_rst;
    logic prev_rdy;

    task automatic track(input int k);
        for (int j = 0; j < N_CH; j++)
            if (prev_rst[j] && !rst_out[j] && fall[j] < 0) fall[j] = k;
        if (!prev_rdy && ready && rdy_rise < 0) rdy_rise = k;
        prev_rst = rst_out;
        prev_rdy = ready;
    endtask

    task automatic clear_track();
        for (int j = 0; j < N_CH; j++) fall[j] = -1;
        rdy_rise = -1;
        prev_rst = rst_out;
        prev_rdy = ready;
    endtask

    initial begin
        // Reset state
        repeat (3) tick();
        chk("reset_rst_out", 32'(rst_out), 32'hF);
        chk("reset_ready", 32'(ready), 32'h0);

        // Lock held from edge 0: releases at 22/38/54/70
        rst_n = 1'b1;
        pll_lock = 1'b1;
        clear_track();
        for (int k = 0; k < 80; k++) begin
            tick();
            track(k);
            if (k == 21) chk("t1_pre_release", 32'(rst_out), 32'hF);
        end
        chk("t1_fall0", 32'(fall[0]), 32'd22);
        chk("t1_fall1", 32'(fall[1]), 32'd38);
        chk("t1_fall2", 32'(fall[2]), 32'd54);
        chk("t1_fall3", 32'(fall[3]), 32'd70);
        chk("t1_ready", 32'(rdy_rise), 32'd70);

        // Software request for domain 2 while running
        sw_rst_req = 4'b0100;
        tick();
        sw_rst_req = '0;
        chk("t3_rst", 32'(rst_out), 32'hC);
        chk("t3_ready", 32'(ready), 32'h0);
        clear_track();
        for (int k = 1; k <= 40; k++) begin
            tick();
            track(k);
        end
        chk("t3_fall2", 32'(fall[2]), 32'd16);
        chk("t3_fall3", 32'(fall[3]), 32'd32);
        chk("t3_ready", 32'(rdy_rise), 32'd32);

        // Stretching at ch=2: higher index ignored, lower index accepted
        sw_rst_req = 4'b0100;
        tick();
        sw_rst_req = '0;
        repeat (5) tick();
        sw_rst_req = 4'b1000;
        tick();
        chk("t4_ignore", 32'(rst_out), 32'hC);
        sw_rst_req = 4'b1010;
        tick();
        sw_rst_req = '0;
        chk("t4_accept", 32'(rst_out), 32'hE);
        repeat (60) tick();
        chk("t4_run", 32'(ready), 32'h1);

        // Lock drop together with a request: lock loss wins within 3 edges
        pll_lock = 1'b0;
        sw_rst_req = 4'b0001;
        tick();
        sw_rst_req = '0;
        repeat (2) tick();
        chk("t5_rst", 32'(rst_out), 32'hF);
        chk("t5_ready", 32'(ready), 32'h0);
`ifdef RST_SEQ_STATS_EN
        chk("t5_llc", 32'(lock_loss_cnt), 32'd1);
`else
        chk("t5_llc", 32'(lock_loss_cnt), 32'd0);
`endif
        repeat (4) tick();

        // One-cycle glitch at edge 3 restarts the filter: rst_out[0] falls at edge 26
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        clear_track();
        for (int k = 0; k < 45; k++) begin
            pll_lock = (k != 3);
            tick();
            track(k);
        end
        chk("t2_fall0", 32'(fall[0]), 32'd26);
        chk("t2_fall1", 32'(fall[1]), 32'd42);

        // Reset mid-sequence aborts immediately
        rst_n = 1'b0;
        tick();
        chk("midrst_rst", 32'(rst_out), 32'hF);
        chk("midrst_ready", 32'(ready), 32'h0);
        rst_n = 1'b1;

        // 300 lock losses: counter saturates
        for (int n = 0; n < 300; n++) begin
            pll_lock = 1'b1;
            repeat (LF + 4) tick();
            pll_lock = 1'b0;
            repeat (4) tick();
        end
`ifdef RST_SEQ_STATS_EN
        chk("t6_sat", 32'(lock_loss_cnt), 32'hFF);
`else
        chk("t6_sat", 32'(lock_loss_cnt), 32'h0);
`endif

        // Random traffic
        pll_lock = 1'b1;
        for (int n = 0; n < 4000; n++) begin
            if (pll_lock) pll_lock = ($urandom_range(0, 99) >= 2);
            else          pll_lock = ($urandom_range(0, 99) < 30);
            sw_rst_req = ($urandom_range(0, 99) < 6) ? N_CH'($urandom) : '0;
            rst_n = ($urandom_range(0, 999) >= 3);
            tick();
        end
        sw_rst_req = '0;
        rst_n = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
